// File: rtl/nmuldiv_unit_if.sv
// Bus between the control unit and the multicycle multiply/divide unit.
// start/busy/done: start is sampled only while busy=0; done pulses for one cycle once hi/lo/Z/dbz are updated.
interface nmuldiv_unit_if #(parameter int N = 32);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] nA;
  logic [N-1:0] nB;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         Z;
  logic         dbz;
  logic [1:0]   dbg_state;

  modport master (output start, op, nA, nB,
                  input  busy, done, hi, lo, Z, dbz, dbg_state);
  modport slave  (input  start, op, nA, nB,
                  output busy, done, hi, lo, Z, dbz, dbg_state);
endinterface

// File: rtl/nmuldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign correction applied in FIX.
module nmuldiv_unit #(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst,
  nmuldiv_unit_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_next;

  logic [1:0]     op_q;
  logic [N-1:0]   a_raw, a_mag, b_mag;
  logic           neg_q, neg_r;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [N:0]     rem;
  logic [N-1:0]   hi_q, lo_q;
  logic           z_q, dbz_q;

  logic           accept, is_div, b_zero, sgn_in;
  logic [N-1:0]   a_in_mag, b_in_mag;
  logic [N:0]     mul_sum, div_shift, rem_next;
  logic           div_ge;
  logic [2*N-1:0] acc_next, prod_fix;
  logic [N-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign is_div = op_q[1];
  assign b_zero = (b_mag == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed modes work on magnitudes; the most-negative value negates to itself,
  // which read as unsigned is exactly 2^(N-1).
  always_comb begin
    sgn_in   = ~bus.op[0];
    a_in_mag = (sgn_in && bus.nA[N-1]) ? -bus.nA : bus.nA;
    b_in_mag = (sgn_in && bus.nB[N-1]) ? -bus.nB : bus.nB;
  end

  // Multiply keeps {partial product, remaining multiplier bits} in acc; divide
  // keeps the dividend/quotient in acc[N-1:0] and the partial remainder in rem.
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = {rem[N-1:0], acc[N-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    acc_next  = acc;
    rem_next  = rem;
    if (is_div) begin
      rem_next = div_ge ? (div_shift - {1'b0, b_mag}) : div_shift;
      acc_next = {acc[2*N-1:N], acc[N-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc[N-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[N-1:0] : acc[N-1:0];
    rem_fix  = neg_r ? -rem[N-1:0] : rem[N-1:0];
    hi_fix   = prod_fix[2*N-1:N];
    lo_fix   = prod_fix[N-1:0];
    if (is_div) begin
      if (b_zero) begin
        hi_fix = a_raw;
        lo_fix = '1;
      end else begin
        hi_fix = rem_fix;
        lo_fix = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_raw <= '0;
      a_mag <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      rem   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= 1'b0;
      dbz_q <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.op;
      a_raw <= bus.nA;
      a_mag <= a_in_mag;
      b_mag <= b_in_mag;
      neg_q <= sgn_in && (bus.nA[N-1] ^ bus.nB[N-1]);
      neg_r <= sgn_in && bus.op[1] && bus.nA[N-1];
      cnt   <= CW'(N - 1);
      rem   <= '0;
      acc   <= bus.op[1] ? {{N{1'b0}}, a_in_mag} : {{N{1'b0}}, b_in_mag};
    end else if (state == RUN) begin
      acc <= acc_next;
      rem <= rem_next;
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      hi_q  <= hi_fix;
      lo_q  <= lo_fix;
      z_q   <= ({hi_fix, lo_fix} == '0);
      dbz_q <= is_div && b_zero;
    end
  end

  assign bus.busy      = (state == RUN) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.Z         = z_q;
  assign bus.dbz       = dbz_q;
  assign bus.dbg_state = state;
endmodule

// File: doc/nmuldiv_unit.md
Name: nmuldiv_unit

Overview:
- Multicycle multiply/divide unit for the N-bit datapath, sitting beside the combinational nALU.
- Executes MIPS-style MULT, MULTU, DIV and DIVU into HI/LO result registers.
- Uses a start/busy/done handshake, so the control unit stalls the pipeline while it iterates.
- Adds over nALU: division, signed modes, a latched 2N-bit result and a divide-by-zero flag.

Parameters:
- N, 32, operand width in bits; must be even and >= 4.

Ports:
- clk    input   1    rising-edge clock
- rst    input   1    asynchronous, active-high reset
- start  input   1    request a new operation; sampled only while busy=0
- op     input   2    00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
- nA     input   N    operand A (multiplicand / dividend); latched on accept
- nB     input   N    operand B (multiplier / divisor); latched on accept
- busy   output  1    high while an operation is in progress
- done   output  1    one-cycle pulse when hi/lo have been updated
- hi     output  N    MULT*: upper product word; DIV*: remainder
- lo     output  N    MULT*: lower product word; DIV*: quotient
- Z      output  1    high when {hi,lo} == 0; registered with hi/lo
- dbz    output  1    divide-by-zero flag of the last completed operation

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, Z=0, dbz=0.
  - Any in-flight operation is abandoned and leaves no trace.
- States:
  - IDLE: wait for start.
  - RUN: N iterations, counter N-1 down to 0.
  - FIX: apply sign correction, write hi/lo.
  - DONE: done=1 for one cycle.
- Accept:
  - At edge E0 with start=1 and state in {IDLE, DONE}: latch op, nA and nB; go to RUN.
  - While busy=1, start, op, nA and nB are ignored. Operands may change freely after accept.
- Timing:
  - RUN runs edges E1..EN.
  - FIX runs edge E(N+1): writes hi, lo, Z and dbz, then enters DONE.
  - done=1 only in the cycle after E(N+1). The result is first visible N+1 edges after the accepting edge.
  - busy=1 in RUN and FIX; busy=0 in IDLE and DONE.
- DONE -> IDLE on the next edge, unless start=1, which is accepted back-to-back (DONE -> RUN).
- hi, lo, Z and dbz hold their values until the next FIX or reset.
- Signed ops (MULT, DIV):
  - Operate on magnitudes |nA| and |nB|. The most-negative value maps to the unsigned 2^(N-1).
  - Product negative iff the operand signs differ; negate the full 2N-bit result in FIX.
  - Quotient negative iff the signs differ. Remainder takes the dividend's sign.
- Multiply:
  - Shift-add, one multiplier bit per RUN cycle, into a 2N-bit accumulator.
  - {hi,lo} is the exact 2N-bit product, with no overflow.
- Divide:
  - Restoring, one quotient bit per RUN cycle, using an (N+1)-bit partial remainder.
  - Invariant: nA = lo*nB + hi, with |hi| < |nB|.
- Divide by zero (nB=0, DIV or DIVU):
  - Full latency still applies.
  - lo = all ones; hi = nA, unmodified and without sign correction; dbz=1.
  - Any other completed operation sets dbz=0.
- Signed overflow, DIV of -2^(N-1) by -1: lo = -2^(N-1), hi=0, dbz=0. No trap.
- Z is computed from the final corrected {hi,lo}.

Test Plan:
- MULTU nA=32, nB=16, with start accepted at E0 -> done pulse in the cycle after E33; hi=0, lo=512, Z=0, busy low in the done cycle.
- MULT nA=0xFFFFFFFD (-3), nB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV nA=0xFFFFFFF9 (-7), nB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
- DIVU nA=100, nB=0 -> lo=0xFFFFFFFF, hi=100, dbz=1. Following MULTU 0*7 -> hi=lo=0, Z=1, dbz=0.
- Busy-window protection:
  - Pulse start with different op and operands at E5 of a running MULTU 32*16 -> ignored; result is still 512.
  - Change nA/nB after accept -> no effect on the result.
  - Start asserted in the done cycle -> accepted, next done N+1 edges later.
- Assert rst at E10 of a DIVU -> busy, done, hi, lo, Z and dbz are all 0 immediately, without waiting for a clock edge. The next start after reset release completes normally with the correct result.
